pop_arbiter: RTL
================

Name: pop_arbiter

Overview:
- Downstream consumer of the two class FIFOs (D0/D1) produced by the full_logic stage.
- Pops words from D0 and D1 under weighted round-robin and merges them into one registered output stream toward the transmit stage.
- Honours a downstream back-pressure flag and keeps saturating per-class delivered-word counters for debug and verification.

Parameters:
- data_width, 6, word width, matching the D0/D1 FIFO data width.
- weight_d0, 2, maximum consecutive pops granted to D0 before yielding to D1 (range 1..15).
- weight_d1, 1, maximum consecutive pops granted to D1 before yielding to D0 (range 1..15).
- count_width, 8, width of the per-class delivered counters.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; clears all state on a posedge while low.
- D0_empty  input  1  D0 FIFO empty flag.
- D1_empty  input  1  D1 FIFO empty flag.
- data_in_D0  input  data_width  D0 FIFO read data; valid the cycle after D0_pop.
- data_in_D1  input  data_width  D1 FIFO read data; valid the cycle after D1_pop.
- out_almost_full  input  1  downstream pause request.
- D0_pop  output  1  pop strobe to D0 FIFO (registered).
- D1_pop  output  1  pop strobe to D1 FIFO (registered).
- data_out  output  data_width  merged output word.
- valid_out  output  1  data_out is valid this cycle.
- class_out  output  1  source class of data_out (0 = D0, 1 = D1).
- count_D0  output  count_width  words delivered from D0, saturating.
- count_D1  output  count_width  words delivered from D1, saturating.
- idle  output  1  high when in IDLE with no word in flight.

Behaviour:
Reset (reset == 0 at posedge):
- All outputs go to 0, except idle, which goes to 1.
- State = IDLE, preferred class = D0, burst counter = 0.
- In-flight tags are discarded.
- Reset mid-operation drops any popped-but-undelivered word. The bench must not expect it on data_out.

FSM states and transitions:
- IDLE
  - Enter SERVE_D0 when D0 is nonempty and either the preferred class is D0 or D1 is empty.
  - Otherwise enter SERVE_D1 when D1 is nonempty.
  - Otherwise stay in IDLE.
- SERVE_Dx
  - Assert Dx_pop in any cycle where Dx_empty == 0, out_almost_full == 0 and burst < weight_x.
  - Each pop increments burst.
  - Leave the state when burst == weight_x or Dx_empty == 1:
    - If the other class is nonempty: switch to it, reset burst to 0, set preferred class to the other one.
    - Otherwise, if Dx is still nonempty: stay, reset burst to 0.
    - Otherwise: go to IDLE, set preferred class to the other one.

Pop rules:
- D0_pop and D1_pop are never high in the same cycle.
- No pop is issued while out_almost_full == 1. The FSM holds its state and burst.
- A pop is never issued on an empty flag.
- Because pops are registered, decisions use the flags sampled at the previous edge. The FIFOs are required to ignore a pop issued while empty; the block tags that pop invalid and produces no output for it.

Latency and output:
- D0_pop or D1_pop high in cycle N → the FIFO data is sampled in cycle N+1 → valid_out = 1 in cycle N+2, with data_out = the sampled word and class_out = its source.
- valid_out is high for exactly one cycle per successful pop.
- In-flight words (at most 2) are delivered even if out_almost_full rises. The downstream threshold must leave room for 2.

Counters:
- count_Dx increments on each valid_out of class x.
- Saturates at 2^count_width-1 with no wrap.

idle:
- idle = (state == IDLE) and no tag pending.

Decomposition:
- Shared package contents:
  - state encoding: IDLE = 2'b00, SERVE_D0 = 2'b01, SERVE_D1 = 2'b10
  - class IDs: CLS_D0 = 0, CLS_D1 = 1
  - default data_width
- One natural sub-module: sat_counter (parameter count_width; ports clk, reset, inc, count), instantiated twice.
- Everything else is inline.

Test Plan:
- Reset hold: reset = 0 for 3 cycles with both FIFOs nonempty → no pops; all outputs 0; idle = 1.
- D0 only: D0 holds 6'h01..6'h04, D1 empty → 4 consecutive D0_pop; data_out 01, 02, 03, 04 appear 2 cycles after each pop with class_out = 0; count_D0 = 4.
- Weighted RR: D0 holds 6'h01..6'h04, D1 holds 6'h21..6'h24 → output order 01, 02, 21, 03, 04, 22, 23, 24; D0_pop and D1_pop never high together.
- Back-pressure: out_almost_full = 1 mid-burst for 5 cycles → no new pops; the ≤2 in-flight words still emerge; traffic resumes in the same state the cycle after the flag drops.
- Reset mid-stream: reset pulled low one cycle after a D1_pop → no valid_out for that word; counters 0; after release, arbitration restarts with D0 preferred.
- Saturation: count_width = 3, push 10 D1 words → count_D1 stops at 7.

Source files
------------

// File: rtl/pop_arbiter_pkg.sv
// pop_arbiter_pkg: shared state encoding, class IDs and default widths for the pop arbiter
package pop_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SERVE_D0 = 2'b01,
    SERVE_D1 = 2'b10
  } state_e;
  localparam logic CLS_D0 = 1'b0;
  localparam logic CLS_D1 = 1'b1;
  localparam int DATA_WIDTH_DEF = 6;
endpackage

// File: rtl/pop_arbiter_sat_counter.sv
// sat_counter: saturating up-counter that sticks at all-ones
module sat_counter #(
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  output logic [count_width-1:0] count
);
  logic [count_width-1:0] count_q, count_d;
  // next count: step on inc unless already at the ceiling
  always_comb count_d = (inc && count_q != '1) ? count_q + count_width'(1) : count_q;
  // count register, cleared while reset is low
  always_ff @(posedge clk)
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pop_arbiter.sv
// pop_arbiter: weighted round-robin merge of the D0/D1 class FIFOs into one registered stream
module pop_arbiter
  import pop_arbiter_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH_DEF,
  parameter int weight_d0   = 2,
  parameter int weight_d1   = 1,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   D0_empty,
  input  logic                   D1_empty,
  input  logic [data_width-1:0]  data_in_D0,
  input  logic [data_width-1:0]  data_in_D1,
  input  logic                   out_almost_full,
  output logic                   D0_pop,
  output logic                   D1_pop,
  output logic [data_width-1:0]  data_out,
  output logic                   valid_out,
  output logic                   class_out,
  output logic [count_width-1:0] count_D0,
  output logic [count_width-1:0] count_D1,
  output logic                   idle
);
  localparam logic [3:0] W0 = 4'(weight_d0);
  localparam logic [3:0] W1 = 4'(weight_d1);
  state_e state_q, state_d;
  logic pref_q, pref_d;
  logic [3:0] burst_q, burst_d;
  logic pop0_q, pop0_d, pop1_q, pop1_d;
  logic tag_v_q, tag_v_d, tag_c_q, tag_c_d;
  logic valid_q, valid_d, cls_q, cls_d;
  logic [data_width-1:0] data_q, data_d;
  logic on_d1, cur_empty, oth_empty;
  logic [3:0] cur_w;
  assign on_d1     = state_q == SERVE_D1;
  assign cur_empty = on_d1 ? D1_empty : D0_empty;
  assign oth_empty = on_d1 ? D0_empty : D1_empty;
  assign cur_w     = on_d1 ? W1 : W0;
  // arbitration: pick a class, pop up to its weight, then yield; everything freezes under back-pressure
  always_comb begin
    state_d = state_q;
    pref_d  = pref_q;
    burst_d = burst_q;
    pop0_d  = 1'b0;
    pop1_d  = 1'b0;
    if (!out_almost_full) begin
      if (state_q == IDLE) begin
        burst_d = '0;
        if (!D0_empty && (pref_q == CLS_D0 || D1_empty)) state_d = SERVE_D0;
        else if (!D1_empty) state_d = SERVE_D1;
      end else if (burst_q == cur_w || cur_empty) begin
        burst_d = '0;
        if (!oth_empty) begin
          state_d = on_d1 ? SERVE_D0 : SERVE_D1;
          pref_d  = on_d1 ? CLS_D0 : CLS_D1;
        end else if (cur_empty) begin
          state_d = IDLE;
          pref_d  = on_d1 ? CLS_D0 : CLS_D1;
        end
      end else begin
        burst_d = burst_q + 4'd1;
        pop0_d  = !on_d1;
        pop1_d  = on_d1;
      end
    end
  end
  // datapath: a pop seen against a nonempty FIFO becomes a valid tag, whose word is captured a cycle later
  always_comb begin
    tag_v_d = (pop0_q && !D0_empty) || (pop1_q && !D1_empty);
    tag_c_d = pop1_q ? CLS_D1 : CLS_D0;
    valid_d = tag_v_q;
    cls_d   = tag_c_q;
    data_d  = tag_v_q ? (tag_c_q == CLS_D1 ? data_in_D1 : data_in_D0) : data_q;
  end
  // state and output registers, all cleared while reset is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pref_q  <= CLS_D0;
      burst_q <= '0;
      pop0_q  <= 1'b0;
      pop1_q  <= 1'b0;
      tag_v_q <= 1'b0;
      tag_c_q <= CLS_D0;
      valid_q <= 1'b0;
      cls_q   <= CLS_D0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pref_q  <= pref_d;
      burst_q <= burst_d;
      pop0_q  <= pop0_d;
      pop1_q  <= pop1_d;
      tag_v_q <= tag_v_d;
      tag_c_q <= tag_c_d;
      valid_q <= valid_d;
      cls_q   <= cls_d;
      data_q  <= data_d;
    end
  end
  sat_counter #(.count_width(count_width)) u_cnt_d0 (
    .clk  (clk),
    .reset(reset),
    .inc  (valid_q && cls_q == CLS_D0),
    .count(count_D0)
  );
  sat_counter #(.count_width(count_width)) u_cnt_d1 (
    .clk  (clk),
    .reset(reset),
    .inc  (valid_q && cls_q == CLS_D1),
    .count(count_D1)
  );
  assign D0_pop    = pop0_q;
  assign D1_pop    = pop1_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign class_out = cls_q;
  assign idle      = state_q == IDLE && !pop0_q && !pop1_q && !tag_v_q;
endmodule
